// File: rtl/alu_exec_unit.sv
// ALU execute unit: op/func decode, single-cycle arithmetic/logic, and an
// iterative shift-add MULT, behind valid/ready handshakes on both sides.
module alu_exec_unit #(
  parameter int unsigned WIDTH  = 32,
  parameter bit          MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       op,
  input  logic [5:0]       func,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output logic             illegal,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam int unsigned MSB   = WIDTH - 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  typedef enum logic [2:0] {
    K_ADD, K_SUB, K_AND, K_OR, K_NOR, K_SLT, K_MUL, K_ILL
  } kind_t;

  state_t           state_q,   state_d;
  logic [WIDTH-1:0] result_q,  result_d;
  logic             zero_q,    zero_d;
  logic             ovf_q,     ovf_d;
  logic             illegal_q, illegal_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] mcand_q,   mcand_d;
  logic [WIDTH-1:0] mplier_q,  mplier_d;
  logic [WIDTH-1:0] acc_q,     acc_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;

  kind_t            kind_c;
  logic [WIDTH-1:0] sum_c;
  logic [WIDTH-1:0] diff_c;
  logic [WIDTH-1:0] res_c;
  logic             ovf_c;
  logic [WIDTH-1:0] acc_next_c;
  logic             accept_c;
  logic             mul_last_c;

  // Decode main-decoder op and R-type func into an operation kind.
  always_comb begin
    kind_c = K_ILL;
    unique case (op)
      2'b00: begin
        unique case (func)
          6'b100000: kind_c = K_ADD;
          6'b100010: kind_c = K_SUB;
          6'b100100: kind_c = K_AND;
          6'b100101: kind_c = K_OR;
          6'b100111: kind_c = K_NOR;
          6'b101010: kind_c = K_SLT;
          6'b011000: kind_c = MUL_EN ? K_MUL : K_ILL;
          default:   kind_c = K_ILL;
        endcase
      end
      2'b01:   kind_c = K_ADD;
      2'b10:   kind_c = K_SUB;
      default: kind_c = K_ILL;
    endcase
  end

  // Single-cycle datapath: result and signed-overflow flag.
  always_comb begin
    sum_c  = a + b;
    diff_c = a - b;
    res_c  = '0;
    ovf_c  = 1'b0;
    unique case (kind_c)
      K_ADD: begin
        res_c = sum_c;
        ovf_c = (a[MSB] == b[MSB]) && (sum_c[MSB] != a[MSB]);
      end
      K_SUB: begin
        res_c = diff_c;
        ovf_c = (a[MSB] != b[MSB]) && (diff_c[MSB] != a[MSB]);
      end
      K_AND:   res_c = a & b;
      K_OR:    res_c = a | b;
      K_NOR:   res_c = ~(a | b);
      K_SLT:   res_c = WIDTH'($signed(a) < $signed(b));
      default: res_c = '0;
    endcase
  end

  // One shift-add step of the multiplier.
  always_comb begin
    acc_next_c = acc_q + (mplier_q[0] ? mcand_q : '0);
    mul_last_c = (cnt_q == CNT_W'(WIDTH - 1));
  end

  // Accept only when idle and the output slot is free or draining this edge.
  assign in_ready = (state_q == S_IDLE) && (!out_valid_q || out_ready);
  assign accept_c = in_valid && in_ready;

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    illegal_d   = illegal_q;
    out_valid_d = out_valid_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          if (kind_c == K_MUL) begin
            state_d     = S_MUL;
            mcand_d     = a;
            mplier_d    = b;
            acc_d       = '0;
            cnt_d       = '0;
            out_valid_d = 1'b0;
          end else begin
            result_d    = res_c;
            zero_d      = (res_c == '0);
            ovf_d       = ovf_c;
            illegal_d   = (kind_c == K_ILL);
            out_valid_d = 1'b1;
          end
        end else if (out_ready) begin
          out_valid_d = 1'b0;
        end
      end
      S_MUL: begin
        acc_d    = acc_next_c;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (mul_last_c) begin
          state_d     = S_IDLE;
          cnt_d       = '0;
          result_d    = acc_next_c;
          zero_d      = (acc_next_c == '0);
          ovf_d       = 1'b0;
          illegal_d   = 1'b0;
          out_valid_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      result_q    <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      illegal_q   <= 1'b0;
      out_valid_q <= 1'b0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      illegal_q   <= illegal_d;
      out_valid_q <= out_valid_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
    end
  end

  assign result    = result_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;
  assign illegal   = illegal_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit (MULT-enabled and MULT-disabled builds).
module tb_alu_exec_unit;

  localparam int unsigned W = 32;

  logic         clk;
  logic         rst_n;
  logic [1:0]   op;
  logic [5:0]   func;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         in_valid;
  logic         out_ready;

  logic         in_ready;
  logic [W-1:0] result;
  logic         zero, ovf, illegal, out_valid;

  logic         in_ready_n;
  logic [W-1:0] result_n;
  logic         zero_n, ovf_n, illegal_n, out_valid_n;

  int n_cmp = 0;
  int n_err = 0;

  alu_exec_unit #(.WIDTH(W), .MUL_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .func(func), .a(a), .b(b),
    .in_valid(in_valid), .in_ready(in_ready), .result(result), .zero(zero),
    .ovf(ovf), .illegal(illegal), .out_valid(out_valid), .out_ready(out_ready)
  );

  alu_exec_unit #(.WIDTH(W), .MUL_EN(1'b0)) dut_nomul (
    .clk(clk), .rst_n(rst_n), .op(op), .func(func), .a(a), .b(b),
    .in_valid(in_valid), .in_ready(in_ready_n), .result(result_n), .zero(zero_n),
    .ovf(ovf_n), .illegal(illegal_n), .out_valid(out_valid_n), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [1:0] o, input logic [5:0] f,
                     input logic [W-1:0] x, input logic [W-1:0] y);
    op = o; func = f; a = x; b = y; in_valid = 1'b1;
  endtask

  task automatic chk_out(input string tag, input logic [W-1:0] r, input logic z,
                         input logic v, input logic il);
    chk({tag, ".valid"},   64'(out_valid), 64'(1'b1));
    chk({tag, ".result"},  64'(result),    64'(r));
    chk({tag, ".zero"},    64'(zero),      64'(z));
    chk({tag, ".ovf"},     64'(ovf),       64'(v));
    chk({tag, ".illegal"}, 64'(illegal),   64'(il));
  endtask

  initial begin
    rst_n = 1'b0; op = 2'b00; func = 6'b0; a = '0; b = '0;
    in_valid = 1'b0; out_ready = 1'b1;
    #12;
    chk("rst.valid",    64'(out_valid), 64'(0));
    chk("rst.result",   64'(result),    64'(0));
    chk("rst.zero",     64'(zero),      64'(0));
    chk("rst.ovf",      64'(ovf),       64'(0));
    chk("rst.illegal",  64'(illegal),   64'(0));
    chk("rst.in_ready", 64'(in_ready),  64'(1));
    @(negedge clk); rst_n = 1'b1;
    #1;

    // Single-cycle ops, back to back
    req(2'b00, 6'b100000, 32'd5, 32'd7);             tick(); chk_out("add", 32'd12, 0, 0, 0);
    req(2'b10, 6'b0, 32'h7FFF_FFFF, 32'hFFFF_FFFF);  tick(); chk_out("sub_ovf", 32'h8000_0000, 0, 1, 0);
    req(2'b10, 6'b0, 32'd9, 32'd9);                  tick(); chk_out("sub_zero", 32'd0, 1, 0, 0);
    req(2'b00, 6'b101010, 32'hFFFF_FFFE, 32'd3);     tick(); chk_out("slt", 32'd1, 0, 0, 0);
    req(2'b00, 6'b101010, 32'd3, 32'hFFFF_FFFE);     tick(); chk_out("slt_f", 32'd0, 1, 0, 0);
    req(2'b00, 6'b100111, 32'd0, 32'd0);             tick(); chk_out("nor", 32'hFFFF_FFFF, 0, 0, 0);
    req(2'b00, 6'b100100, 32'h0000_F0F0, 32'h0000_FF00); tick(); chk_out("and", 32'h0000_F000, 0, 0, 0);
    req(2'b00, 6'b100101, 32'h0000_F0F0, 32'h0000_FF00); tick(); chk_out("or", 32'h0000_FFF0, 0, 0, 0);
    req(2'b01, 6'b111111, 32'h7FFF_FFFF, 32'd1);     tick(); chk_out("addi_ovf", 32'h8000_0000, 0, 1, 0);
    req(2'b00, 6'b100000, 32'hFFFF_FFFF, 32'd1);     tick(); chk_out("add_wrap", 32'd0, 1, 0, 0);
    req(2'b11, 6'b100000, 32'd5, 32'd5);             tick(); chk_out("op11", 32'd0, 1, 0, 1);
    req(2'b00, 6'b000000, 32'd5, 32'd5);             tick(); chk_out("func0", 32'd0, 1, 0, 1);
    in_valid = 1'b0; tick();
    chk("drain.valid", 64'(out_valid), 64'(0));

    // MULT with a second request held during the iterations
    req(2'b00, 6'b011000, 32'd1234, 32'd5678);
    chk("mul.in_ready", 64'(in_ready), 64'(1));
    tick();
    req(2'b01, 6'b0, 32'd1, 32'd2);
    chk("nomul.valid",   64'(out_valid_n), 64'(1));
    chk("nomul.illegal", 64'(illegal_n),   64'(1));
    chk("nomul.result",  64'(result_n),    64'(0));
    chk("nomul.zero",    64'(zero_n),      64'(1));
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("mul_busy%0d.in_ready", i),  64'(in_ready),  64'(0));
      chk($sformatf("mul_busy%0d.valid", i),     64'(out_valid), 64'(0));
      tick();
    end
    chk_out("mul", 32'd7006652, 0, 0, 0);
    chk("mul_done.in_ready", 64'(in_ready), 64'(1));
    tick();
    chk_out("held_add", 32'd3, 0, 0, 0);
    in_valid = 1'b0; tick();

    // Back-pressure
    req(2'b00, 6'b100000, 32'd100, 32'd23); tick();
    chk_out("bp_first", 32'd123, 0, 0, 0);
    req(2'b01, 6'b0, 32'd10, 32'd20);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("bp%0d.in_ready", i), 64'(in_ready), 64'(0));
      chk_out($sformatf("bp%0d", i), 32'd123, 0, 0, 0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release.in_ready", 64'(in_ready), 64'(1));
    tick();
    chk_out("bp_next", 32'd30, 0, 0, 0);
    in_valid = 1'b0; tick();
    chk("bp_drain.valid", 64'(out_valid), 64'(0));

    // Reset in the middle of a MULT
    req(2'b00, 6'b011000, 32'd3, 32'd3); tick();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("mid_mul.in_ready", 64'(in_ready), 64'(0));
    rst_n = 1'b0;
    #1;
    chk("mid_rst.valid",    64'(out_valid), 64'(0));
    chk("mid_rst.in_ready", 64'(in_ready),  64'(1));
    chk("mid_rst.result",   64'(result),    64'(0));
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 35; i++) tick();
    chk("post_rst.valid",    64'(out_valid), 64'(0));
    chk("post_rst.in_ready", 64'(in_ready),  64'(1));
    req(2'b01, 6'b0, 32'd2, 32'd2); tick();
    chk_out("post_rst_add", 32'd4, 0, 0, 0);
    in_valid = 1'b0; tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Parametrised successor to the combinational ALU op decoder: it decodes the 2-bit main-decoder op and the 6-bit R-type func field, then executes the operation on WIDTH-bit operands.
- Extends the operation set with SLT, NOR and an iterative multi-cycle MULT, plus status flags and an illegal-op indication.
- Sits between register read and writeback in the multicycle datapath.
- Uses a valid/ready handshake on input and output so the core can stall on MULT.

Parameters:
- WIDTH, 32: operand/result width in bits (>=4).
- MUL_EN, 1: 1 = MULT supported; 0 = MULT func decodes as illegal.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- op  in  2  main-decoder op: 00 R-type, 01 I-type add, 10 BEQ subtract, 11 reserved.
- func  in  6  R-type function field; used only when op=00.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request this cycle.
- result  out  WIDTH  registered result.
- zero  out  1  result == 0.
- ovf  out  1  signed overflow (ADD/SUB only, else 0).
- illegal  out  1  op/func not decoded; result forced to 0.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer accepts result.

Behaviour:
- Reset (async assert, sync release): state=IDLE, out_valid=0, result=0, zero=0, ovf=0, illegal=0, iteration counter=0. in_ready=1 after reset.
- Decode, op=00:
  - 100000 ADD
  - 100010 SUB
  - 100100 AND
  - 100101 OR
  - 100111 NOR
  - 101010 SLT (signed; result 1 or 0 zero-extended)
  - 011000 MULT (low WIDTH bits of a*b, unsigned)
  - any other func → illegal.
- Decode, other op: op=01 → ADD; op=10 → SUB; op=11 → illegal.
- Handshake:
  - Request accepted on a rising edge where in_valid && in_ready.
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - Output (result, zero, ovf, illegal) holds stable while out_valid && !out_ready.
  - out_valid clears on an out_ready edge unless a new single-cycle result loads on the same edge.
- Single-cycle ops and illegal: result and flags are registered on the acceptance edge; out_valid=1 in the next cycle (latency 1). Back-to-back accepts give one result per cycle when out_ready=1.
- MULT FSM, states IDLE → MUL → IDLE:
  - On accept: latch a into multiplicand and b into multiplier, clear the accumulator, set counter=0, state=MUL, out_valid drops to 0 (the previous result is consumed on the same edge).
  - In MUL, each cycle: if multiplier[0], acc += multiplicand; then multiplicand <<= 1, multiplier >>= 1, counter++. All arithmetic is truncated to WIDTH.
  - Early termination is not allowed: exactly WIDTH iterations.
  - After the final iteration (counter==WIDTH-1) the result is loaded and state=IDLE. out_valid=1 exactly WIDTH cycles after the acceptance edge.
  - zero is computed on the product; ovf=0.
- Flags:
  - ADD ovf = (a[msb]==b[msb]) && (res[msb]!=a[msb]).
  - SUB ovf = (a[msb]!=b[msb]) && (res[msb]!=a[msb]).
  - zero is computed on the final WIDTH-bit result for every op, including illegal (result=0 → zero=1).
- Wrap-around: ADD/SUB wrap modulo 2^WIDTH; ovf only flags it.
- Reset mid-MULT: reset aborts immediately to reset values and no result is produced. Inputs seen while in MUL are ignored (in_ready=0).
- MUL_EN=0: MULT func → illegal, latency 1.

Test Plan:
- Reset then op=00 func=100000 a=5 b=7, out_ready=1 → next cycle result=12, zero=0, ovf=0, out_valid=1.
- op=10 a=0x7FFFFFFF b=0xFFFFFFFF → result=0x80000000, ovf=1. Then op=10 a=9 b=9 → result=0, zero=1.
- op=00 func=101010 a=0xFFFFFFFE(-2) b=3 → result=1. Then func=100111 a=0 b=0 → result=0xFFFFFFFF.
- MULT a=1234 b=5678 → in_ready=0 for 32 cycles, result=7006652 with out_valid rising exactly 32 cycles after accept; a second in_valid held during MUL is accepted only after completion.
- Back-pressure: single-cycle ADD result with out_ready=0 for 5 cycles → result/flags stable, in_ready=0. Raising out_ready for one cycle accepts the pending in_valid on the same edge.
- op=11 and op=00 func=000000 → illegal=1, result=0, zero=1. Reset asserted at MUL cycle 10 → out_valid=0, state IDLE, in_ready=1 after release. MUL_EN=0 build: MULT → illegal next cycle.
